// File: rtl/instr_cache_responder_pkg.sv
// -----------------------------------------------------------------------------
// instr_cache_pkg
// Shared definitions for the direct-mapped instruction cache responder:
// default geometry, derived address-field widths, the NOP returned when no
// instruction is available, the idle PC sentinel and the refill FSM states.
// -----------------------------------------------------------------------------
package instr_cache_pkg;

    localparam int NUM_SETS        = 8;
    localparam int WORDS_PER_BLOCK = 4;

    localparam int OFFSET_W   = $clog2(WORDS_PER_BLOCK);
    localparam int INDEX_W    = $clog2(NUM_SETS);
    localparam int TAG_W      = 32 - INDEX_W - OFFSET_W - 2;
    localparam int BLOCK_W    = 32 * WORDS_PER_BLOCK;
    localparam int BLK_ADDR_W = 32 - OFFSET_W - 2;

    localparam logic [31:0] NOP       = 32'h0000_0013;
    localparam logic [31:0] IDLE_ADDR = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_READ = 2'd1,
        UPDATE   = 2'd2
    } state_e;

    // Word address bits [31:2] all ones means the fetch unit is not requesting.
    function automatic logic is_idle_addr(input logic [29:0] word_addr);
        return (word_addr == IDLE_ADDR[31:2]);
    endfunction

endpackage

// File: rtl/instr_cache_responder_if.sv
// -----------------------------------------------------------------------------
// instr_cache_responder_if
// Bundles the fetch-side request/response signals, the refill handshake with
// instruction memory and the performance counter outputs.
//   slave  : the cache (consumes address/stall/memory data, drives the rest)
//   master : the environment (fetch unit + instruction memory)
// -----------------------------------------------------------------------------
interface instr_cache_responder_if;
    import instr_cache_pkg::*;

    logic [31:0]            address;
    logic                   stall;
    logic [31:0]            instruction;
    logic                   busywait;
    logic                   mem_read;
    logic [BLK_ADDR_W-1:0]  mem_address;
    logic [BLOCK_W-1:0]     mem_readdata;
    logic                   mem_busywait;
    logic [31:0]            hit_count;
    logic [31:0]            miss_count;

    modport slave (
        input  address, stall, mem_readdata, mem_busywait,
        output instruction, busywait, mem_read, mem_address, hit_count, miss_count
    );

    modport master (
        output address, stall, mem_readdata, mem_busywait,
        input  instruction, busywait, mem_read, mem_address, hit_count, miss_count
    );

endinterface

// File: rtl/instr_cache_perf_counter.sv
// -----------------------------------------------------------------------------
// instr_cache_perf_counter
// 32-bit event counter that sticks at all-ones instead of wrapping.
//   clock : rising-edge clock
//   reset : synchronous active-high clear
//   inc   : count one event this cycle
//   count : current (registered) value
// -----------------------------------------------------------------------------
module instr_cache_perf_counter (
    input  logic        clock,
    input  logic        reset,
    input  logic        inc,
    output logic [31:0] count
);

    logic [31:0] count_r;

    // Saturating increment with synchronous clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_r <= 32'd0;
        end else if (inc && (count_r != 32'hFFFF_FFFF)) begin
            count_r <= count_r + 32'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/instr_cache_responder.sv
// -----------------------------------------------------------------------------
// instr_cache_responder
// Direct-mapped instruction cache. Hits return the addressed word
// combinationally; a miss raises busywait in the same cycle and refills the
// whole line from instruction memory (IDLE -> MEM_READ -> UPDATE -> IDLE).
// Hit and miss events feed two saturating performance counters.
//   clock : rising-edge clock
//   reset : synchronous active-high; clears FSM, valid bits and counters
//   bus   : fetch interface, memory refill handshake and counter outputs
// -----------------------------------------------------------------------------
module instr_cache_responder #(
    parameter int NUM_SETS        = instr_cache_pkg::NUM_SETS,
    parameter int WORDS_PER_BLOCK = instr_cache_pkg::WORDS_PER_BLOCK
) (
    input  logic                     clock,
    input  logic                     reset,
    instr_cache_responder_if.slave   bus
);
    import instr_cache_pkg::*;

    localparam int OFF_BITS = $clog2(WORDS_PER_BLOCK);
    localparam int IDX_BITS = $clog2(NUM_SETS);
    localparam int TAG_BITS = 32 - IDX_BITS - OFF_BITS - 2;
    localparam int BLK_BITS = 32 - OFF_BITS - 2;

    state_e                 state_r;
    logic [NUM_SETS-1:0]    valid_r;
    logic [TAG_BITS-1:0]    tag_r  [NUM_SETS];
    logic [31:0]            data_r [NUM_SETS][WORDS_PER_BLOCK];
    logic [BLK_BITS-1:0]    blk_addr_r;

    logic [OFF_BITS-1:0]    offset_s;
    logic [IDX_BITS-1:0]    idx_s;
    logic [TAG_BITS-1:0]    tag_s;
    logic [IDX_BITS-1:0]    fill_idx_s;
    logic [TAG_BITS-1:0]    fill_tag_s;
    logic                   sentinel_s;
    logic                   hit_s;
    logic                   lookup_hit_s;
    logic                   miss_s;
    logic                   fill_s;
    logic                   busywait_s;
    logic [31:0]            instruction_s;
    logic                   unused_s;

    assign offset_s   = bus.address[OFF_BITS+1:2];
    assign idx_s      = bus.address[IDX_BITS+OFF_BITS+1:OFF_BITS+2];
    assign tag_s      = bus.address[31:32-TAG_BITS];
    assign sentinel_s = is_idle_addr(bus.address[31:2]);
    assign unused_s   = ^bus.address[1:0];

    // The latched block address already carries the refill line's index and tag.
    assign fill_idx_s = blk_addr_r[IDX_BITS-1:0];
    assign fill_tag_s = blk_addr_r[BLK_BITS-1:IDX_BITS];

    assign hit_s        = valid_r[idx_s] && (tag_r[idx_s] == tag_s);
    assign lookup_hit_s = (state_r == IDLE) && !sentinel_s && hit_s;
    assign miss_s       = (state_r == IDLE) && !sentinel_s && !hit_s;
    assign fill_s       = (state_r == MEM_READ) && !bus.mem_busywait;

    // Fetch response: word on a hit or idle NOP, otherwise stall with NOP.
    always_comb begin
        busywait_s    = 1'b1;
        instruction_s = NOP;
        case (state_r)
            IDLE: begin
                if (sentinel_s) begin
                    busywait_s    = 1'b0;
                    instruction_s = NOP;
                end else if (hit_s) begin
                    busywait_s    = 1'b0;
                    instruction_s = data_r[idx_s][offset_s];
                end else begin
                    busywait_s    = 1'b1;
                    instruction_s = NOP;
                end
            end
            default: begin
                busywait_s    = 1'b1;
                instruction_s = NOP;
            end
        endcase
    end

    assign bus.busywait    = busywait_s;
    assign bus.instruction = instruction_s;
    assign bus.mem_read    = (state_r == MEM_READ);
    assign bus.mem_address = blk_addr_r;

    // Refill FSM and per-line valid bits.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r    <= IDLE;
            valid_r    <= '0;
            blk_addr_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (miss_s) begin
                        blk_addr_r <= bus.address[31:OFF_BITS+2];
                        state_r    <= MEM_READ;
                    end else begin
                        state_r    <= IDLE;
                    end
                end
                MEM_READ: begin
                    if (!bus.mem_busywait) begin
                        valid_r[fill_idx_s] <= 1'b1;
                        state_r             <= UPDATE;
                    end else begin
                        state_r             <= MEM_READ;
                    end
                end
                UPDATE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Line tag/data storage; not cleared by reset, and a reset edge blocks the write.
    always_ff @(posedge clock) begin
        if (fill_s && !reset) begin
            tag_r[fill_idx_s] <= fill_tag_s;
            for (int w = 0; w < WORDS_PER_BLOCK; w++) begin
                data_r[fill_idx_s][w] <= bus.mem_readdata[w*32 +: 32];
            end
        end
    end

    instr_cache_perf_counter u_hit_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (lookup_hit_s && !bus.stall),
        .count (bus.hit_count)
    );

    instr_cache_perf_counter u_miss_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (miss_s),
        .count (bus.miss_count)
    );

endmodule
